comp_1b: RTL and testbench



---
 rtl/comp_1b_pkg.sv | 65 ++++++
 rtl/comp_1b_core.sv | 56 +++++
 rtl/comp_1b.sv | 74 +++++++
 tb/tb_comp_1b.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/comp_1b_pkg.sv
// -----------------------------------------------------------------------------
// comp_1b_pkg
//   Shared types and pure helper functions for the comp_1b magnitude
//   comparator family.
//
//   cmp_result_t : one-hot-by-construction compare outcome (EQ / GT / LT)
//   cmp_extend   : widens a WIDTH-bit operand to the common working width,
//                  sign- or zero-extending so the numeric value is preserved
//   cmp_eval     : compares two extended operands under signed/unsigned rules
//   casc_resolve : folds possibly non-one-hot cascade inputs into one result
//                  (priority gt > lt > eq, all-zero means equal)
// -----------------------------------------------------------------------------
package comp_1b_pkg;

  // Widest operand any instance may use; operands are widened to this.
  localparam int unsigned CMP_MAX_W = 64;

  typedef logic [CMP_MAX_W-1:0] cmp_word_t;

  typedef enum logic [1:0] {
    CMP_EQ = 2'd0,
    CMP_GT = 2'd1,
    CMP_LT = 2'd2
  } cmp_result_t;

  // Widening preserves the operand's value, so comparing the extended words
  // is the same as comparing the original full-width operands.
  function automatic cmp_word_t cmp_extend(input cmp_word_t   raw,
                                           input int unsigned width,
                                           input logic        is_signed);
    cmp_word_t ext;
    ext = raw;
    for (int unsigned i = 0; i < CMP_MAX_W; i++) begin
      if (i >= width) begin
        ext[i] = is_signed ? raw[width-1] : 1'b0;
      end
    end
    return ext;
  endfunction

  function automatic cmp_result_t cmp_eval(input cmp_word_t a,
                                           input cmp_word_t b,
                                           input logic      is_signed);
    if (a == b) begin
      return CMP_EQ;
    end
    if (is_signed) begin
      return ($signed(a) > $signed(b)) ? CMP_GT : CMP_LT;
    end
    return (a > b) ? CMP_GT : CMP_LT;
  endfunction

  function automatic cmp_result_t casc_resolve(input logic eq,
                                               input logic gt,
                                               input logic lt);
    cmp_result_t res;
    casez ({gt, lt, eq})
      3'b1??:  res = CMP_GT;
      3'b01?:  res = CMP_LT;
      default: res = CMP_EQ;  // eq alone, or nothing asserted
    endcase
    return res;
  endfunction

endpackage : comp_1b_pkg

// File: rtl/comp_1b_core.sv
// -----------------------------------------------------------------------------
// comp_1b_core
//   Purely combinational compare of a against b plus cascade merge.
//   Build option: COMP_1B_CASCADE_EN adds the casc_* inputs; when a==b the
//   result is taken from the (priority-resolved) cascade, otherwise the local
//   compare wins. Without the macro the cascade behaves as tied to "equal".
//
//   Parameters : WIDTH  operand width (1..CMP_MAX_W)
//                SIGNED 1 = two's complement operands, 0 = unsigned
//   Ports      : a, b         operands
//                casc_*_in    cascade from lower-significance stage (optional)
//                result       merged compare outcome
// -----------------------------------------------------------------------------
module comp_1b_core
  import comp_1b_pkg::*;
#(
  parameter int unsigned WIDTH  = 1,
  parameter bit          SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef COMP_1B_CASCADE_EN
  input  logic             casc_eq_in,
  input  logic             casc_gt_in,
  input  logic             casc_lt_in,
`endif
  output cmp_result_t      result
);

  cmp_word_t   a_raw;
  cmp_word_t   b_raw;
  cmp_result_t local_res;
  cmp_result_t casc_res;

  always_comb begin
    // NOTE: every variable gets a default before any partial write, so no
    // path leaves a bit unassigned and no latch is inferred.
    a_raw            = '0;
    b_raw            = '0;
    a_raw[WIDTH-1:0] = a;
    b_raw[WIDTH-1:0] = b;
    local_res = cmp_eval(cmp_extend(a_raw, WIDTH, SIGNED),
                         cmp_extend(b_raw, WIDTH, SIGNED),
                         SIGNED);
  end

`ifdef COMP_1B_CASCADE_EN
  assign casc_res = casc_resolve(casc_eq_in, casc_gt_in, casc_lt_in);
`else
  assign casc_res = casc_resolve(1'b1, 1'b0, 1'b0);
`endif

  // Only a tie at this stage defers to the lower-significance stage.
  assign result = (local_res == CMP_EQ) ? casc_res : local_res;

endmodule : comp_1b_core

// File: rtl/comp_1b.sv
// -----------------------------------------------------------------------------
// comp_1b
//   Registered magnitude comparator with mutually exclusive aeb/agb/alb flags.
//   One cycle of latency, one compare per cycle, synchronous active-low reset.
//   Build option: COMP_1B_CASCADE_EN exposes casc_eq_in/casc_gt_in/casc_lt_in.
//
//   Parameters : WIDTH  operand width in bits (>=1)
//                SIGNED 1 = two's complement, 0 = unsigned
//   Ports      : clk        rising-edge clock
//                rst_n      synchronous active-low reset
//                in_valid   sample a/b on this edge
//                a, b       operands
//                casc_*_in  cascade inputs (COMP_1B_CASCADE_EN only)
//                out_valid  flags hold a result sampled on the previous edge
//                aeb/agb/alb  equal / greater / less
// -----------------------------------------------------------------------------
module comp_1b
  import comp_1b_pkg::*;
#(
  parameter int unsigned WIDTH  = 1,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef COMP_1B_CASCADE_EN
  input  logic             casc_eq_in,
  input  logic             casc_gt_in,
  input  logic             casc_lt_in,
`endif
  output logic             out_valid,
  output logic             aeb,
  output logic             agb,
  output logic             alb
);

  cmp_result_t result;

  comp_1b_core #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_core (
    .a          (a),
    .b          (b),
`ifdef COMP_1B_CASCADE_EN
    .casc_eq_in (casc_eq_in),
    .casc_gt_in (casc_gt_in),
    .casc_lt_in (casc_lt_in),
`endif
    .result     (result)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      aeb       <= 1'b0;
      agb       <= 1'b0;
      alb       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Flags only load on a valid sample; otherwise the last result is kept.
      if (in_valid) begin
        aeb <= (result == CMP_EQ);
        agb <= (result == CMP_GT);
        alb <= (result == CMP_LT);
      end
    end
  end

endmodule : comp_1b

// File: tb/tb_comp_1b.sv
// -----------------------------------------------------------------------------
// tb_comp_1b
//   Four comparators share one stimulus stream: 1-bit unsigned, 1-bit signed,
//   8-bit unsigned, 8-bit signed (1-bit instances see bit 0 of the operands).
//   A model based on integer values predicts {out_valid, aeb, agb, alb}.
// -----------------------------------------------------------------------------
module tb_comp_1b;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       casc_eq;
  logic       casc_gt;
  logic       casc_lt;

  logic [3:0] obs   [4];
  logic [3:0] exp_q [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  comp_1b #(.WIDTH(1), .SIGNED(1'b0)) u_w1u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8[0]), .b(b8[0]),
`ifdef COMP_1B_CASCADE_EN
    .casc_eq_in(casc_eq), .casc_gt_in(casc_gt), .casc_lt_in(casc_lt),
`endif
    .out_valid(obs[0][3]), .aeb(obs[0][2]), .agb(obs[0][1]), .alb(obs[0][0]));

  comp_1b #(.WIDTH(1), .SIGNED(1'b1)) u_w1s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8[0]), .b(b8[0]),
`ifdef COMP_1B_CASCADE_EN
    .casc_eq_in(casc_eq), .casc_gt_in(casc_gt), .casc_lt_in(casc_lt),
`endif
    .out_valid(obs[1][3]), .aeb(obs[1][2]), .agb(obs[1][1]), .alb(obs[1][0]));

  comp_1b #(.WIDTH(8), .SIGNED(1'b0)) u_w8u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8),
`ifdef COMP_1B_CASCADE_EN
    .casc_eq_in(casc_eq), .casc_gt_in(casc_gt), .casc_lt_in(casc_lt),
`endif
    .out_valid(obs[2][3]), .aeb(obs[2][2]), .agb(obs[2][1]), .alb(obs[2][0]));

  comp_1b #(.WIDTH(8), .SIGNED(1'b1)) u_w8s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8),
`ifdef COMP_1B_CASCADE_EN
    .casc_eq_in(casc_eq), .casc_gt_in(casc_gt), .casc_lt_in(casc_lt),
`endif
    .out_valid(obs[3][3]), .aeb(obs[3][2]), .agb(obs[3][1]), .alb(obs[3][0]));

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic int dut_width(input int k);
    return (k < 2) ? 1 : 8;
  endfunction

  function automatic bit dut_signed(input int k);
    return (k == 1) || (k == 3);
  endfunction

  // Numeric value of an operand as seen by instance k.
  function automatic int num_val(input logic [7:0] x, input int k);
    int w;
    int v;
    w = dut_width(k);
    v = (w == 1) ? int'(x[0]) : int'(x);
    if (dut_signed(k) && v >= (1 << (w - 1))) v -= (1 << w);
    return v;
  endfunction

  // Expected {aeb, agb, alb}: compare numbers; on a tie follow the cascade.
  function automatic logic [2:0] ref_flags(input int va, input int vb,
                                           input logic ce, input logic cg,
                                           input logic cl);
    if (va > vb) return 3'b010;
    if (va < vb) return 3'b001;
`ifdef COMP_1B_CASCADE_EN
    if (cg) return 3'b010;
    if (cl) return 3'b001;
    return 3'b100;
`else
    if (ce || cg || cl) return 3'b100;
    return 3'b100;
`endif
  endfunction

  task automatic step(input logic r, input logic iv, input logic [7:0] va,
                      input logic [7:0] vb, input logic ce, input logic cg,
                      input logic cl);
    rst_n    = r;
    in_valid = iv;
    a8       = va;
    b8       = vb;
    casc_eq  = ce;
    casc_gt  = cg;
    casc_lt  = cl;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (!r) begin
        exp_q[k] = 4'b0000;
      end else if (iv) begin
        exp_q[k] = {1'b1, ref_flags(num_val(va, k), num_val(vb, k), ce, cg, cl)};
      end else begin
        exp_q[k] = {1'b0, exp_q[k][2:0]};
      end
    end
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("model_dut%0d", k), 32'(obs[k]), 32'(exp_q[k]));
      if (obs[k][3]) check($sformatf("onehot_dut%0d", k),
                           32'($countones(obs[k][2:0])), 32'd1);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) exp_q[k] = 4'b0000;

    // Reset state
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) check("reset", 32'(obs[k]), 32'h0);

    // 1-bit unsigned sequence
    step(1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    check("seq00", 32'(obs[0]), 32'b1100);
    step(1'b1, 1'b1, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
    check("seq10", 32'(obs[0]), 32'b1010);
    check("w1s_1_vs_0", 32'(obs[1]), 32'b1001);
    step(1'b1, 1'b1, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0);
    check("seq11", 32'(obs[0]), 32'b1100);
    step(1'b1, 1'b1, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    check("seq01", 32'(obs[0]), 32'b1001);
    step(1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    check("seq00b", 32'(obs[0]), 32'b1100);

    // Mid-stream reset discards the sample, next edge loads it
    step(1'b0, 1'b1, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
    check("rst_mid", 32'(obs[0]), 32'b0000);
    step(1'b1, 1'b1, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
    check("rst_release", 32'(obs[0]), 32'b1010);

    // Hold when in_valid is low
    step(1'b1, 1'b0, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    check("hold", 32'(obs[0]), 32'b0010);

    // 8-bit sign boundary
    step(1'b1, 1'b1, 8'h80, 8'h7f, 1'b1, 1'b0, 1'b0);
    check("s8_80_7f", 32'(obs[3]), 32'b1001);
    check("u8_80_7f", 32'(obs[2]), 32'b1010);
    step(1'b1, 1'b1, 8'hff, 8'h01, 1'b1, 1'b0, 1'b0);
    check("s8_ff_01", 32'(obs[3]), 32'b1001);

`ifdef COMP_1B_CASCADE_EN
    step(1'b1, 1'b1, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
    check("casc_gt", 32'(obs[0]), 32'b1010);
    step(1'b1, 1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1);
    check("casc_ignored", 32'(obs[0]), 32'b1010);
    step(1'b1, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
    check("casc_zero", 32'(obs[0]), 32'b1100);
    step(1'b1, 1'b1, 8'h01, 8'h01, 1'b1, 1'b1, 1'b1);
    check("casc_prio", 32'(obs[0]), 32'b1010);
`endif

    // Randomized run against the model
    for (int n = 0; n < 1000; n++) begin
      logic       r;
      logic       iv;
      logic [7:0] va;
      logic [7:0] vb;
      logic       ce;
      logic       cg;
      logic       cl;
      r  = ($urandom_range(0, 63) != 0);
      iv = ($urandom_range(0, 3) != 0);
      va = 8'($urandom);
      vb = ($urandom_range(0, 3) == 0) ? va : 8'($urandom);
`ifdef COMP_1B_CASCADE_EN
      ce = 1'($urandom);
      cg = 1'($urandom);
      cl = 1'($urandom);
`else
      ce = 1'b1;
      cg = 1'b0;
      cl = 1'b0;
`endif
      step(r, iv, va, vb, ce, cg, cl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_comp_1b
